// File: rtl/seq_accumulator.sv
// seq_accumulator: collects N_SAMPLES unsigned BW-bit samples into an ACC_W-bit
// sum and holds the result until downstream takes it. The datapath uses
// library cells (fa, fd2, simple gates). Every cell reports its transistor
// count on number; the top reports the sum over all of its instances.
//
// Ports:
//   CLK, RESET        clock (posedge) and asynchronous active-low reset
//   i_valid, o_ready  sample handshake (o_ready = not HOLD)
//   i_data [BW]       unsigned sample
//   o_valid, i_ready  result handshake (o_valid = HOLD)
//   o_sum [ACC_W]     accumulator register
//   o_ovf             sticky carry-out of the current frame
//   o_count [CNT_W]   samples accepted in the current frame
//   number [51]       total transistor count of the instantiated cells
//
// state | meaning
// ACC   | hold_q = 0, accepting samples
// HOLD  | hold_q = 1, frame result presented, waiting for i_ready

module inv (input logic a, output logic y, output logic [50:0] number);
  assign y = ~a;
  assign number = 51'd2;
endmodule

module and2 (input logic a, input logic b, output logic y, output logic [50:0] number);
  assign y = a & b;
  assign number = 51'd6;
endmodule

module or2 (input logic a, input logic b, output logic y, output logic [50:0] number);
  assign y = a | b;
  assign number = 51'd6;
endmodule

module mux2 (input logic s, input logic d0, input logic d1, output logic y,
             output logic [50:0] number);
  assign y = s ? d1 : d0;
  assign number = 51'd12;
endmodule

module fd2 (input logic CLK, input logic RESET, input logic d, output logic q,
            output logic [50:0] number);
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) q <= 1'b0;
    else        q <= d;
  end
  assign number = 51'd26;
endmodule

module fa #(parameter int BW = 8) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          ci,
  output logic [BW-1:0] s,
  output logic          co,
  output logic [50:0]   number
);
  logic [BW:0] c;
  assign c[0] = ci;
  for (genvar k = 0; k < BW; k++) begin : g_bit
    assign s[k]   = a[k] ^ b[k] ^ c[k];
    assign c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
  end
  assign co = c[BW];
  assign number = 51'(28 * BW);
endmodule

module seq_accumulator #(
  parameter int BW        = 8,
  parameter int ACC_W     = 10,
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [BW-1:0]    i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_count,
  output logic [50:0]      number
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  logic             hold_q, hold_d, ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum, acc_keep;
  logic [CNT_W-1:0] cnt_q, cnt_d, inc, inc_g, term, chain;
  logic             carry, cnt_co_unused;
  logic             n_hold, n_iready, n_release, n_last, last;
  logic             accept, frame_end, release_r, ovf_or, ovf_keep;

  logic [50:0] n_fa_acc, n_fa_cnt, n_hold_ff, n_ovf_ff, n_hold_mux;
  logic [50:0] n_ovf_or, n_ovf_and, n_ovf_mux;
  logic [50:0] n_inv [4];
  logic [50:0] n_ctl [3];
  logic [50:0] n_acc_ff [ACC_W];
  logic [50:0] n_acc_and [ACC_W];
  logic [50:0] n_acc_mux [ACC_W];
  logic [50:0] n_cnt_ff [CNT_W];
  logic [50:0] n_cnt_and [CNT_W];
  logic [50:0] n_cnt_mux [CNT_W];
  logic [50:0] n_term [CNT_W];
  logic [50:0] n_chain [CNT_W];

  // Control
  inv  u_n_hold   (.a(hold_q),    .y(n_hold),    .number(n_inv[0]));
  inv  u_n_iready (.a(i_ready),   .y(n_iready),  .number(n_inv[1]));
  inv  u_n_rel    (.a(release_r), .y(n_release), .number(n_inv[2]));
  inv  u_n_last   (.a(last),      .y(n_last),    .number(n_inv[3]));
  and2 u_accept   (.a(n_hold), .b(i_valid), .y(accept),    .number(n_ctl[0]));
  and2 u_fend     (.a(accept), .b(last),    .y(frame_end), .number(n_ctl[1]));
  and2 u_release  (.a(hold_q), .b(i_ready), .y(release_r), .number(n_ctl[2]));

  // HOLD persists while i_ready is low; ACC moves to HOLD on the last sample.
  mux2 u_hold_mux (.s(hold_q), .d0(frame_end), .d1(n_iready), .y(hold_d),
                   .number(n_hold_mux));
  fd2  u_hold_ff  (.CLK(CLK), .RESET(RESET), .d(hold_d), .q(hold_q), .number(n_hold_ff));

  // cnt == N_SAMPLES-1: AND chain over per-bit literal matches
  for (genvar k = 0; k < CNT_W; k++) begin : g_term
    if (LAST[k]) begin : g_one
      assign term[k]   = cnt_q[k];
      assign n_term[k] = '0;
    end else begin : g_zero
      inv u_t (.a(cnt_q[k]), .y(term[k]), .number(n_term[k]));
    end
    if (k == 0) begin : g_first
      assign chain[k]   = term[k];
      assign n_chain[k] = '0;
    end else begin : g_next
      and2 u_c (.a(chain[k-1]), .b(term[k]), .y(chain[k]), .number(n_chain[k]));
    end
  end
  assign last = chain[CNT_W-1];

  // Accumulator: accept loads the sum; release clears; otherwise hold.
  fa #(.BW(ACC_W)) u_fa_acc (.a(acc_q), .b(ACC_W'(i_data)), .ci(1'b0), .s(sum),
                             .co(carry), .number(n_fa_acc));
  for (genvar k = 0; k < ACC_W; k++) begin : g_acc
    and2 u_keep (.a(acc_q[k]), .b(n_release), .y(acc_keep[k]), .number(n_acc_and[k]));
    mux2 u_mux  (.s(accept), .d0(acc_keep[k]), .d1(sum[k]), .y(acc_d[k]),
                 .number(n_acc_mux[k]));
    fd2  u_ff   (.CLK(CLK), .RESET(RESET), .d(acc_d[k]), .q(acc_q[k]),
                 .number(n_acc_ff[k]));
  end

  or2  u_ovf_or  (.a(ovf_q), .b(carry), .y(ovf_or), .number(n_ovf_or));
  and2 u_ovf_and (.a(ovf_q), .b(n_release), .y(ovf_keep), .number(n_ovf_and));
  mux2 u_ovf_mux (.s(accept), .d0(ovf_keep), .d1(ovf_or), .y(ovf_d), .number(n_ovf_mux));
  fd2  u_ovf_ff  (.CLK(CLK), .RESET(RESET), .d(ovf_d), .q(ovf_q), .number(n_ovf_ff));

  // Counter: increment on accept, forced to 0 when the last sample lands
  // (cnt+1 need not wrap naturally when N_SAMPLES < 2^CNT_W).
  fa #(.BW(CNT_W)) u_fa_cnt (.a(cnt_q), .b('0), .ci(1'b1), .s(inc),
                             .co(cnt_co_unused), .number(n_fa_cnt));
  for (genvar k = 0; k < CNT_W; k++) begin : g_cnt
    and2 u_gate (.a(inc[k]), .b(n_last), .y(inc_g[k]), .number(n_cnt_and[k]));
    mux2 u_mux  (.s(accept), .d0(cnt_q[k]), .d1(inc_g[k]), .y(cnt_d[k]),
                 .number(n_cnt_mux[k]));
    fd2  u_ff   (.CLK(CLK), .RESET(RESET), .d(cnt_d[k]), .q(cnt_q[k]),
                 .number(n_cnt_ff[k]));
  end

  assign o_valid = hold_q;
  assign o_ready = n_hold;
  assign o_sum   = acc_q;
  assign o_ovf   = ovf_q;
  assign o_count = cnt_q;

  always_comb begin
    number = n_fa_acc + n_fa_cnt + n_hold_ff + n_ovf_ff + n_hold_mux
           + n_ovf_or + n_ovf_and + n_ovf_mux;
    for (int k = 0; k < 4; k++) number = number + n_inv[k];
    for (int k = 0; k < 3; k++) number = number + n_ctl[k];
    for (int k = 0; k < ACC_W; k++)
      number = number + n_acc_ff[k] + n_acc_and[k] + n_acc_mux[k];
    for (int k = 0; k < CNT_W; k++)
      number = number + n_cnt_ff[k] + n_cnt_and[k] + n_cnt_mux[k]
             + n_term[k] + n_chain[k];
  end
endmodule

// File: tb/tb_seq_accumulator.sv
module tb_seq_accumulator;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  // instance a: defaults; instance b: ACC_W = 8 for the wrap case
  logic       a_i_valid = 0, a_i_ready = 1, a_o_ready, a_o_valid, a_o_ovf;
  logic [7:0] a_i_data = 0;
  logic [9:0] a_o_sum;
  logic [1:0] a_o_count;
  logic [50:0] a_number;

  logic       b_i_valid = 0, b_i_ready = 1, b_o_ready, b_o_valid, b_o_ovf;
  logic [7:0] b_i_data = 0;
  logic [7:0] b_o_sum;
  logic [1:0] b_o_count;
  logic [50:0] b_number;

  seq_accumulator u_dut_a (
    .CLK(CLK), .RESET(RESET), .i_valid(a_i_valid), .o_ready(a_o_ready),
    .i_data(a_i_data), .o_valid(a_o_valid), .i_ready(a_i_ready),
    .o_sum(a_o_sum), .o_ovf(a_o_ovf), .o_count(a_o_count), .number(a_number));

  seq_accumulator #(.ACC_W(8)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .i_valid(b_i_valid), .o_ready(b_o_ready),
    .i_data(b_i_data), .o_valid(b_o_valid), .i_ready(b_i_ready),
    .o_sum(b_o_sum), .o_ovf(b_o_ovf), .o_count(b_o_count), .number(b_number));

  // Cell costs: fa 28/bit, fd2 26, inv 2, and2 6, or2 6, mux2 12.
  // ACC_W=10,CNT_W=2: fa 280+56, fd2 14*26=364, inv 4*2=8, and2 17*6=102,
  //                   or2 6, mux2 14*12=168  -> 984
  // ACC_W=8, CNT_W=2: fa 224+56, fd2 12*26=312, inv 8, and2 15*6=90,
  //                   or2 6, mux2 12*12=144  -> 840
  localparam logic [50:0] NUM_A = 51'd984;
  localparam logic [50:0] NUM_B = 51'd840;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [50:0] obs, input logic [50:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int gd [7] = '{5, 0, 6, 0, 0, 7, 8};
  int gv [7] = '{1, 0, 1, 0, 0, 1, 1};
  int gc [7] = '{1, 1, 2, 2, 2, 3, 0};

  initial begin
    // reset state
    #2;
    chk("rst_valid", a_o_valid, 0);
    chk("rst_ready", a_o_ready, 1);
    chk("rst_sum",   a_o_sum,   0);
    chk("rst_ovf",   a_o_ovf,   0);
    chk("rst_count", a_o_count, 0);
    chk("num_a",     a_number,  NUM_A);
    chk("num_b",     b_number,  NUM_B);
    #6 RESET = 1'b1;

    // 1,2,3,4 back-to-back
    a_i_valid = 1; a_i_data = 1; tick();
    chk("t1_cnt1", a_o_count, 1); chk("t1_sum1", a_o_sum, 1);
    a_i_data = 2; tick();
    chk("t1_cnt2", a_o_count, 2); chk("t1_sum2", a_o_sum, 3);
    a_i_data = 3; tick();
    chk("t1_cnt3", a_o_count, 3); chk("t1_sum3", a_o_sum, 6);
    a_i_data = 4; tick();
    chk("t1_valid", a_o_valid, 1); chk("t1_ready", a_o_ready, 0);
    chk("t1_sum",   a_o_sum, 10);  chk("t1_ovf",   a_o_ovf, 0);
    chk("t1_cnt",   a_o_count, 0);
    a_i_valid = 0; tick();
    chk("t1_done_valid", a_o_valid, 0); chk("t1_done_sum", a_o_sum, 0);
    chk("t1_done_cnt", a_o_count, 0);

    // 255 x4 on a; 200,100,0,0 on b (ACC_W = 8)
    a_i_valid = 1; a_i_data = 255; b_i_valid = 1; b_i_data = 200; tick();
    b_i_data = 100; tick();
    chk("t2b_sum2", b_o_sum, 44); chk("t2b_ovf2", b_o_ovf, 1);
    b_i_data = 0; tick();
    chk("t2a_sum3", a_o_sum, 765);
    tick();
    chk("t2a_valid", a_o_valid, 1); chk("t2a_sum", a_o_sum, 1020);
    chk("t2a_ovf", a_o_ovf, 0);
    chk("t2b_valid", b_o_valid, 1); chk("t2b_sum", b_o_sum, 44);
    chk("t2b_ovf", b_o_ovf, 1);
    a_i_valid = 0; b_i_valid = 0; tick();
    chk("t2b_clr_ovf", b_o_ovf, 0); chk("t2b_clr_sum", b_o_sum, 0);
    chk("t2a_clr_valid", a_o_valid, 0);

    // backpressure
    a_i_ready = 0; a_i_valid = 1; a_i_data = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_valid", a_o_valid, 1); chk("t3_sum", a_o_sum, 4);
    a_i_data = 7;
    for (int i = 0; i < 5; i++) begin
      a_i_valid = (i % 2 == 0);
      tick();
      chk("t3_hold_valid", a_o_valid, 1); chk("t3_hold_ready", a_o_ready, 0);
      chk("t3_hold_sum", a_o_sum, 4);     chk("t3_hold_cnt", a_o_count, 0);
    end
    a_i_ready = 1; a_i_valid = 1; tick();
    chk("t3_rel_valid", a_o_valid, 0); chk("t3_rel_ready", a_o_ready, 1);
    chk("t3_rel_sum", a_o_sum, 0);     chk("t3_rel_cnt", a_o_count, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_next_valid", a_o_valid, 1); chk("t3_next_sum", a_o_sum, 28);
    a_i_valid = 0; tick();
    chk("t3_next_done", a_o_valid, 0);

    // gapped input
    for (int i = 0; i < 7; i++) begin
      a_i_valid = gv[i][0]; a_i_data = 8'(gd[i]); tick();
      chk("t4_cnt", a_o_count, 51'(gc[i]));
    end
    chk("t4_valid", a_o_valid, 1); chk("t4_sum", a_o_sum, 26);
    a_i_valid = 0; tick();

    // async reset mid-frame
    a_i_valid = 1; a_i_data = 9; tick(); tick();
    chk("t5_pre_sum", a_o_sum, 18);
    a_i_valid = 0;
    #2 RESET = 1'b0;
    #1;
    chk("t5_rst_sum", a_o_sum, 0); chk("t5_rst_cnt", a_o_count, 0);
    chk("t5_rst_valid", a_o_valid, 0);
    @(negedge CLK); RESET = 1'b1;
    tick(); tick();
    chk("t5_no_pulse", a_o_valid, 0);
    a_i_valid = 1; a_i_data = 5;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_valid", a_o_valid, 1); chk("t5_sum", a_o_sum, 20);
    a_i_valid = 0; tick();

    chk("num_a_end", a_number, NUM_A);
    chk("num_b_end", b_number, NUM_B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
